// File: rtl/whackmole_game_ctrl.sv
// whackmole_game_ctrl: game sequencer for the whack-a-mole datapath.
//  Owns the live mole pattern and paces pattern changes and the game clock from clk.
//  It asks the RNG for new values, accumulates a saturating score from hit_reg, and clears
//  moles once they are hit.
// Ports:
//  clk        system clock, all state on posedge
//  rst_n      asynchronous active-low reset
//  start      one-cycle start request (accepted in IDLE and OVER)
//  rand_val   current RNG output, sampled on pattern loads
//  hit_reg    hits from the whack datapath
//  moles      live mole pattern to the datapath
//  rand_next  one-cycle pulse after each pattern load: RNG must advance
//  score      hits this game, saturating at all-ones
//  time_left  game ticks remaining
//  playing    high while a game is running
//  game_over  high after a game has ended, until the next start
module whackmole_game_ctrl #(
   parameter int unsigned N          = 18,
   parameter int unsigned TICK_DIV   = 50_000_000,
   parameter int unsigned MOLE_TICKS = 2,
   parameter int unsigned GAME_TICKS = 60,
   parameter int unsigned SCORE_W    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [N-1:0]       rand_val,
   input  logic [N-1:0]       hit_reg,
   output logic [N-1:0]       moles,
   output logic               rand_next,
   output logic [SCORE_W-1:0] score,
   output logic [7:0]         time_left,
   output logic               playing,
   output logic               game_over
);

   localparam int unsigned TCW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned MCW  = $clog2(MOLE_TICKS + 1);
   localparam int unsigned PCW  = $clog2(N + 1);
   // Sum width wide enough that score + popcount never wraps before the saturation test.
   localparam int unsigned SUMW = ((SCORE_W > PCW) ? SCORE_W : PCW) + 1;
   localparam logic [SUMW-1:0] SCORE_MAX = (SUMW'(1) << SCORE_W) - SUMW'(1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_OVER   = 2'd2;

   logic [1:0]         state, state_next;
   logic [TCW-1:0]     tick_cnt, tick_cnt_next;
   logic [MCW-1:0]     mole_cnt, mole_cnt_next;
   logic [N-1:0]       moles_next, load_val, hits;
   logic [SCORE_W-1:0] score_next;
   logic [7:0]         time_left_next;
   logic               rand_pulse_next;
   logic               tick;
   logic [PCW-1:0]     pop;
   logic [SUMW-1:0]    score_sum;

   always_comb begin
      // A zero RNG value would leave the board empty; substitute a single mole.
      load_val = (rand_val == '0) ? N'(1) : rand_val;
      hits     = hit_reg & moles;
      pop      = '0;
      for (int i = 0; i < N; i++) begin
         pop = pop + PCW'(hits[i]);
      end
      score_sum = SUMW'(score) + SUMW'(pop);
      tick      = (state == ST_ACTIVE) && (tick_cnt == TCW'(TICK_DIV - 1));

      state_next      = state;
      tick_cnt_next   = tick_cnt;
      mole_cnt_next   = mole_cnt;
      moles_next      = moles;
      score_next      = score;
      time_left_next  = time_left;
      rand_pulse_next = 1'b0;

      case (state)
         ST_IDLE, ST_OVER: begin
            tick_cnt_next = '0;
            if (start) begin
               state_next      = ST_ACTIVE;
               score_next      = '0;
               time_left_next  = 8'(GAME_TICKS);
               mole_cnt_next   = MCW'(MOLE_TICKS);
               moles_next      = load_val;
               rand_pulse_next = 1'b1;
            end
         end
         ST_ACTIVE: begin
            tick_cnt_next = tick ? '0 : tick_cnt + TCW'(1);
            score_next    = (score_sum > SCORE_MAX) ? '1 : score_sum[SCORE_W-1:0];
            moles_next    = moles & ~hit_reg;
            // Reload and game end override the hit mask; hits are still scored above.
            if (tick) begin
               time_left_next = time_left - 8'd1;
               if (time_left == 8'd1) begin
                  state_next = ST_OVER;
                  moles_next = '0;
               end else begin
                  mole_cnt_next = mole_cnt - MCW'(1);
                  if (mole_cnt == MCW'(1)) begin
                     moles_next      = load_val;
                     mole_cnt_next   = MCW'(MOLE_TICKS);
                     rand_pulse_next = 1'b1;
                  end
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         tick_cnt  <= '0;
         mole_cnt  <= '0;
         moles     <= '0;
         rand_next <= 1'b0;
         score     <= '0;
         time_left <= 8'd0;
         playing   <= 1'b0;
         game_over <= 1'b0;
      end else begin
         state     <= state_next;
         tick_cnt  <= tick_cnt_next;
         mole_cnt  <= mole_cnt_next;
         moles     <= moles_next;
         rand_next <= rand_pulse_next;
         score     <= score_next;
         time_left <= time_left_next;
         // Decoded from the next state so the flags line up with the state register.
         playing   <= (state_next == ST_ACTIVE);
         game_over <= (state_next == ST_OVER);
      end
   end

endmodule

// File: tb/tb_whackmole_game_ctrl.sv
module tb_whackmole_game_ctrl;

   localparam int TD = 4;
   localparam int MT = 2;
   localparam int GT = 5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [17:0] rand_val;
   logic [17:0] hit_reg;

   logic [17:0] moles, moles_s;
   logic        rand_next, rand_next_s;
   logic [15:0] score;
   logic [1:0]  score_s;
   logic [7:0]  time_left, time_left_s;
   logic        playing, playing_s;
   logic        game_over, game_over_s;

   always #5 clk = ~clk;

   whackmole_game_ctrl #(.N(18), .TICK_DIV(TD), .MOLE_TICKS(MT), .GAME_TICKS(GT), .SCORE_W(16))
   u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .rand_val(rand_val), .hit_reg(hit_reg),
      .moles(moles), .rand_next(rand_next), .score(score), .time_left(time_left),
      .playing(playing), .game_over(game_over)
   );

   whackmole_game_ctrl #(.N(18), .TICK_DIV(TD), .MOLE_TICKS(MT), .GAME_TICKS(GT), .SCORE_W(2))
   u_small (
      .clk(clk), .rst_n(rst_n), .start(start), .rand_val(rand_val), .hit_reg(hit_reg),
      .moles(moles_s), .rand_next(rand_next_s), .score(score_s), .time_left(time_left_s),
      .playing(playing_s), .game_over(game_over_s)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: elapsed cycles in the game, unbounded score, current pattern.
   bit          m_active, m_over, m_rn;
   int          m_e, m_score;
   logic [17:0] m_pat;

   function automatic logic [17:0] load(input logic [17:0] x);
      return (x == 18'h0) ? 18'h00001 : x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_over = 0; m_rn = 0; m_e = 0; m_score = 0; m_pat = '0;
   endtask

   task automatic model_step(input logic s, input logic [17:0] rv, input logic [17:0] h);
      int k;
      m_rn = 0;
      if (!m_active) begin
         if (s) begin
            m_active = 1; m_over = 0; m_e = 0; m_score = 0; m_pat = load(rv); m_rn = 1;
         end
      end else begin
         m_score += $countones(h & m_pat);
         k = ((m_e + 1) % TD == 0) ? (m_e + 1) / TD : 0;
         if (k == GT) begin
            m_active = 0; m_over = 1; m_pat = '0;
         end else if (k != 0 && k % MT == 0) begin
            m_pat = load(rv); m_rn = 1;
         end else begin
            m_pat = m_pat & ~h;
         end
         m_e++;
      end
   endtask

   task automatic check_model();
      int tl;
      tl = m_active ? GT - m_e / TD : 0;
      chk("moles", 32'(moles), 32'(m_pat));
      chk("rand_next", 32'(rand_next), 32'(m_rn));
      chk("score", 32'(score), (m_score > 65535) ? 32'd65535 : 32'(m_score));
      chk("time_left", 32'(time_left), 32'(tl));
      chk("playing", 32'(playing), 32'(m_active));
      chk("game_over", 32'(game_over), 32'(m_over));
      chk("score_w2", 32'(score_s), (m_score > 3) ? 32'd3 : 32'(m_score));
      chk("moles_w2", 32'(moles_s), 32'(m_pat));
      chk("rand_next_w2", 32'(rand_next_s), 32'(m_rn));
      chk("time_left_w2", 32'(time_left_s), 32'(tl));
      chk("playing_w2", 32'(playing_s), 32'(m_active));
      chk("game_over_w2", 32'(game_over_s), 32'(m_over));
   endtask

   task automatic step(input logic s, input logic [17:0] rv, input logic [17:0] h);
      start = s; rand_val = rv; hit_reg = h;
      model_step(s, rv, h);
      @(posedge clk);
      #1;
      check_model();
   endtask

   typedef struct {
      logic        st;
      logic [17:0] rv;
      logic [17:0] hit;
      logic [17:0] moles;
      logic [15:0] score;
      logic [7:0]  tl;
      logic        rn;
      logic        play;
      logic        over;
   } vec_t;

   vec_t vecs [24];

   initial begin
      int cnt;
      int guard;
      logic [17:0] h;
      logic [17:0] rv;

      // Inputs -> outputs after the following edge. Rows 2..21 are the 20 ACTIVE cycles.
      vecs[0]  = '{1'b0, 18'h000F0, 18'h00000, 18'h000F0 & 18'h0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 18'h000F0, 18'h00000, 18'h000F0, 16'd0, 8'd5, 1'b1, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 18'h000F0, 18'h00030, 18'h000C0, 16'd2, 8'd5, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 18'h000F0, 18'h00030, 18'h000C0, 16'd2, 8'd5, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 18'h000F0, 18'h00000, 18'h000C0, 16'd2, 8'd5, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 18'h000F0, 18'h00000, 18'h000C0, 16'd2, 8'd4, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 18'h000F0, 18'h00000, 18'h000C0, 16'd2, 8'd4, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 18'h000F0, 18'h00000, 18'h000C0, 16'd2, 8'd4, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 18'h000F0, 18'h00000, 18'h000C0, 16'd2, 8'd4, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 18'h03000, 18'h00040, 18'h03000, 16'd3, 8'd3, 1'b1, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 18'h00000, 18'h00000, 18'h03000, 16'd3, 8'd3, 1'b0, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 18'h00000, 18'h00000, 18'h03000, 16'd3, 8'd3, 1'b0, 1'b1, 1'b0};
      vecs[12] = '{1'b0, 18'h00000, 18'h00000, 18'h03000, 16'd3, 8'd3, 1'b0, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 18'h00000, 18'h00000, 18'h03000, 16'd3, 8'd2, 1'b0, 1'b1, 1'b0};
      vecs[14] = '{1'b0, 18'h00000, 18'h00000, 18'h03000, 16'd3, 8'd2, 1'b0, 1'b1, 1'b0};
      vecs[15] = '{1'b0, 18'h00000, 18'h00000, 18'h03000, 16'd3, 8'd2, 1'b0, 1'b1, 1'b0};
      vecs[16] = '{1'b0, 18'h00000, 18'h00000, 18'h03000, 16'd3, 8'd2, 1'b0, 1'b1, 1'b0};
      vecs[17] = '{1'b0, 18'h00000, 18'h00000, 18'h00001, 16'd3, 8'd1, 1'b1, 1'b1, 1'b0};
      vecs[18] = '{1'b0, 18'h00000, 18'h00000, 18'h00001, 16'd3, 8'd1, 1'b0, 1'b1, 1'b0};
      vecs[19] = '{1'b0, 18'h00000, 18'h00000, 18'h00001, 16'd3, 8'd1, 1'b0, 1'b1, 1'b0};
      vecs[20] = '{1'b0, 18'h00000, 18'h00000, 18'h00001, 16'd3, 8'd1, 1'b0, 1'b1, 1'b0};
      vecs[21] = '{1'b0, 18'h00000, 18'h00001, 18'h00000, 16'd4, 8'd0, 1'b0, 1'b0, 1'b1};
      vecs[22] = '{1'b0, 18'h0ABCD, 18'h3FFFF, 18'h00000, 16'd4, 8'd0, 1'b0, 1'b0, 1'b1};
      vecs[23] = '{1'b0, 18'h0ABCD, 18'h3FFFF, 18'h00000, 16'd4, 8'd0, 1'b0, 1'b0, 1'b1};

      rst_n = 1'b0; start = 1'b0; rand_val = 18'h000F0; hit_reg = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_model();
      rst_n = 1'b1;

      // Idle: nothing moves and the RNG is never asked to advance.
      for (int i = 0; i < 20; i++) step(1'b0, 18'h000F0, 18'h0);

      // Directed game.
      for (int i = 0; i < 24; i++) begin
         step(vecs[i].st, vecs[i].rv, vecs[i].hit);
         chk($sformatf("vec%0d.moles", i), 32'(moles), 32'(vecs[i].moles));
         chk($sformatf("vec%0d.score", i), 32'(score), 32'(vecs[i].score));
         chk($sformatf("vec%0d.time_left", i), 32'(time_left), 32'(vecs[i].tl));
         chk($sformatf("vec%0d.rand_next", i), 32'(rand_next), 32'(vecs[i].rn));
         chk($sformatf("vec%0d.playing", i), 32'(playing), 32'(vecs[i].play));
         chk($sformatf("vec%0d.game_over", i), 32'(game_over), 32'(vecs[i].over));
      end

      // Restart from OVER clears the held score; five single hits saturate the 2-bit score.
      step(1'b1, 18'h0001F, 18'h0);
      chk("restart_score", 32'(score), 32'd0);
      chk("restart_playing", 32'(playing), 32'd1);
      for (int i = 0; i < 5; i++) begin
         h = 18'h00001 << i;
         step(1'b0, 18'h0001F, h);
      end
      chk("sat_score_w2", 32'(score_s), 32'd3);
      chk("sat_score_w16", 32'(score), 32'd5);

      // Game length measured in cycles with playing high.
      guard = 0;
      while (!game_over && guard < 100) begin
         step(1'b0, 18'h00F00, 18'h0);
         guard++;
      end
      chk("wait_over_timeout", 32'(game_over), 32'd1);
      step(1'b1, 18'h00F00, 18'h0);
      cnt = 1;
      guard = 0;
      while (!game_over && guard < 100) begin
         step(1'b0, 18'h00F00, 18'h0);
         if (playing) cnt++;
         guard++;
      end
      chk("game_length", 32'(cnt), 32'(GT * TD));

      // Asynchronous reset mid-game.
      step(1'b1, 18'h00F00, 18'h0);
      step(1'b0, 18'h00F00, 18'h00100);
      step(1'b0, 18'h00F00, 18'h0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_model();
      @(posedge clk);
      #1;
      check_model();
      rst_n = 1'b1;

      // Randomized play against the model.
      for (int i = 0; i < 1500; i++) begin
         rv = ($urandom_range(0, 7) == 0) ? 18'h0 : 18'($urandom);
         case ($urandom_range(0, 3))
            0: h = 18'h0;
            1: h = m_pat & 18'($urandom);
            2: h = 18'($urandom);
            default: h = m_pat;
         endcase
         step($urandom_range(0, 15) == 0, rv, h);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
